// File: rtl/if_stage_pkg.sv
// Shared pipeline constants and the IF/ID bundle type.
// Provides reset PC, bubble encoding, word size and alignment helper.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES    = 32'd4;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   function automatic logic [31:0] align_word(
      input logic [31:0] a
   );
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus.
// pc: fetch address (master drives), ir: instruction word (slave drives).
interface if_stage_if;

   logic [31:0] pc;
   logic [31:0] ir;

   modport master (output pc, input ir);
   modport slave  (input pc, output ir);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with hold (enable low) and flush.
// Ports: clk, reset (async, high), i_en, i_flush, i_d -> o_q.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_en,
   input  logic   i_flush,
   input  if_id_t i_d,
   output if_id_t o_q
);

   if_id_t r_q;

   // Flush keeps pc4 so the last real return address is preserved.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '{ir: NOP_INSTR, pc4: '0, valid: 1'b0};
      end else if (i_flush) begin
         r_q.ir    <= NOP_INSTR;
         r_q.valid <= 1'b0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall, fault, count.
// Ports: clk, reset, imem (pc out / ir in), stall, redirect,
// redirect_target, if_id_ir/pc4/valid, fetch_fault, fetch_count.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          IMEM_WORDS = 128,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   if_stage_if.master        imem,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_target,
   output logic [31:0]       if_id_ir,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic              fetch_fault,
   output logic [31:0]       fetch_count
);

   localparam logic [29:0] LP_WORDS = IMEM_WORDS[29:0];

   logic [31:0] r_pc;
   logic        r_fault;
   logic [31:0] r_count;

   logic [31:0] w_pc4;
   logic        w_oob;
   logic        w_adv;
   if_id_t      w_d;
   if_id_t      w_q;

   assign w_pc4 = r_pc + WORD_BYTES;
   assign w_oob = (r_pc[31:2] >= LP_WORDS);
   assign w_adv = ~redirect & ~stall;

   // Out-of-range fetch becomes a bubble rather than a real instr.
   always_comb begin
      w_d.ir    = w_oob ? NOP_INSTR : imem.ir;
      w_d.pc4   = w_pc4;
      w_d.valid = ~w_oob;
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_adv),
      .i_flush (redirect),
      .i_d     (w_d),
      .o_q     (w_q)
   );

   // Redirect wins over stall; fault is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
         r_count <= '0;
      end else if (redirect) begin
         r_pc <= align_word(redirect_target);
         if (redirect_target[1:0] != 2'b00) begin
            r_fault <= 1'b1;
         end
      end else if (!stall) begin
         r_pc <= w_pc4;
         if (w_oob) begin
            r_fault <= 1'b1;
         end else begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   assign imem.pc     = r_pc;
   assign if_id_ir    = w_q.ir;
   assign if_id_pc4   = w_q.pc4;
   assign if_id_valid = w_q.valid;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table plus reset/fault sequences.
// Drives imem.ir directly as the combinational memory response.
module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] if_id_ir;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int n_cmp;
   int n_bad;

   if_stage_if imem();

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .imem            (imem),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_id_ir        (if_id_ir),
      .if_id_pc4       (if_id_pc4),
      .if_id_valid     (if_id_valid),
      .fetch_fault     (fetch_fault),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] iir;
      logic [31:0] pc4;
      logic        v;
      logic        flt;
      logic [31:0] cnt;
      logic        pc4_dc;
   } vec_t;

   vec_t tv [13];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic rd,
                        input logic [31:0] tgt, input logic [31:0] ir);
      stall           = st;
      redirect        = rd;
      redirect_target = tgt;
      imem.ir         = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"},    imem.pc,     32'h0);
      chk({tag, ".ir"},    if_id_ir,    NOP_INSTR_DEF);
      chk({tag, ".pc4"},   if_id_pc4,   32'h0);
      chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
      chk({tag, ".fault"}, {31'b0, fetch_fault}, 32'h0);
      chk({tag, ".count"}, fetch_count, 32'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset           = 1'b1;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = '0;
      imem.ir         = '0;

      //         st rd tgt    ir            pc     iir           pc4    v  f  cnt dc
      tv[0]  = '{0, 0, 0,     32'h00222820, 32'h4, 32'h00222820, 32'h4, 1, 0, 1, 0};
      tv[1]  = '{0, 0, 0,     32'h00222820, 32'h8, 32'h00222820, 32'h8, 1, 0, 2, 0};
      tv[2]  = '{1, 0, 0,     32'hFFFFFFFF, 32'h8, 32'h00222820, 32'h8, 1, 0, 2, 0};
      tv[3]  = '{1, 0, 0,     32'hFFFFFFFF, 32'h8, 32'h00222820, 32'h8, 1, 0, 2, 0};
      tv[4]  = '{0, 0, 0,     32'h11111113, 32'hC, 32'h11111113, 32'hC, 1, 0, 3, 0};
      tv[5]  = '{1, 1, 32'h40, 32'h22222223, 32'h40, 32'h0, 32'hC, 0, 0, 3, 0};
      tv[6]  = '{0, 0, 0,     32'hAAAA0013, 32'h44, 32'hAAAA0013, 32'h44, 1, 0, 4, 0};
      tv[7]  = '{0, 1, 32'h1FC, 32'h33333333, 32'h1FC, 32'h0, 32'h44, 0, 0, 4, 0};
      tv[8]  = '{0, 0, 0,     32'hDEADBEEF, 32'h200, 32'hDEADBEEF, 32'h200, 1, 0, 5, 0};
      tv[9]  = '{0, 0, 0,     32'h12345678, 32'h204, 32'h0, 32'h0, 0, 1, 5, 1};
      tv[10] = '{1, 0, 0,     32'h00000005, 32'h204, 32'h0, 32'h0, 0, 1, 5, 1};
      tv[11] = '{0, 1, 32'h8, 32'h00000007, 32'h8, 32'h0, 32'h0, 0, 1, 5, 1};
      tv[12] = '{0, 0, 0,     32'h00A00093, 32'hC, 32'h00A00093, 32'hC, 1, 1, 6, 0};

      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         drive(tv[i].st, tv[i].rd, tv[i].tgt, tv[i].ir);
         chk($sformatf("v%0d.pc", i),  imem.pc,  tv[i].pc);
         chk($sformatf("v%0d.ir", i),  if_id_ir, tv[i].iir);
         if (!tv[i].pc4_dc) begin
            chk($sformatf("v%0d.pc4", i), if_id_pc4, tv[i].pc4);
         end
         chk($sformatf("v%0d.valid", i), {31'b0, if_id_valid},
             {31'b0, tv[i].v});
         chk($sformatf("v%0d.fault", i), {31'b0, fetch_fault},
             {31'b0, tv[i].flt});
         chk($sformatf("v%0d.count", i), fetch_count, tv[i].cnt);
      end

      // Stall at pc=C, then async reset mid-cycle.
      drive(1'b1, 1'b0, 32'h0, 32'h00000099);
      chk("stallC.pc", imem.pc, 32'hC);
      #2;
      reset = 1'b1;
      #1;
      chk_reset("async");

      // Redirect during reset must be discarded.
      redirect        = 1'b1;
      redirect_target = 32'h80;
      @(posedge clk);
      #1;
      chk("rst_redir.pc", imem.pc, 32'h0);
      chk("rst_redir.fault", {31'b0, fetch_fault}, 32'h0);

      @(negedge clk);
      reset    = 1'b0;
      redirect = 1'b0;
      stall    = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h00222820);
      chk("restart.pc", imem.pc, 32'h4);
      chk("restart.pc4", if_id_pc4, 32'h4);
      chk("restart.ir", if_id_ir, 32'h00222820);
      chk("restart.count", fetch_count, 32'h1);

      // Misaligned redirect: aligned fetch, sticky fault.
      drive(1'b0, 1'b1, 32'h42, 32'h0);
      chk("mis.pc", imem.pc, 32'h40);
      chk("mis.fault", {31'b0, fetch_fault}, 32'h1);
      chk("mis.valid", {31'b0, if_id_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h00500093);
      chk("mis1.pc4", if_id_pc4, 32'h44);
      chk("mis1.ir", if_id_ir, 32'h00500093);
      chk("mis1.fault", {31'b0, fetch_fault}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 32'h00600113);
      chk("mis2.pc", imem.pc, 32'h48);
      chk("mis2.count", fetch_count, 32'h3);
      chk("mis2.fault", {31'b0, fetch_fault}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 128: instruction-memory depth in 32-bit words.
REQ-003 Parameter NOP_INSTR, default 32'h00000000: bubble encoding injected into IF/ID.
REQ-004 Port clk input 1: single clock; all state updates on its rising edge.
REQ-005 Port reset input 1: asynchronous, active-high reset.
REQ-006 Port pc output 32: fetch address driven to the instruction memory, equal to the PC register.
REQ-007 Port ir input 32: instruction word returned combinationally by the instruction memory for pc.
REQ-008 Port stall input 1: hazard-unit hold request (load-use).
REQ-009 Port redirect input 1: taken branch or jump resolved downstream.
REQ-010 Port redirect_target input 32: next fetch address when redirect is set.
REQ-011 Port if_id_ir output 32: IF/ID latched instruction.
REQ-012 Port if_id_pc4 output 32: IF/ID latched fetch address + 4.
REQ-013 Port if_id_valid output 1: IF/ID holds a real fetched instruction.
REQ-014 Port fetch_fault output 1: sticky flag for misaligned or out-of-range fetch.
REQ-015 Port fetch_count output 32: count of instructions accepted into IF/ID.

Function
REQ-016 Per-cycle priority SHALL be: reset > redirect > stall > normal advance.
REQ-017 Normal advance SHALL set PC <= PC+4, if_id_ir <= ir, if_id_pc4 <= PC+4, if_id_valid <= 1, fetch_count <= fetch_count+1.
REQ-018 Fetch-to-IF/ID latency SHALL be one cycle: ir sampled in cycle N appears on if_id_ir in cycle N+1.
REQ-019 Stall SHALL hold PC, if_id_ir, if_id_pc4, if_id_valid and fetch_count unchanged.
REQ-020 Redirect SHALL set PC <= {redirect_target[31:2],2'b00}, if_id_ir <= NOP_INSTR, if_id_valid <= 0, if_id_pc4 unchanged, fetch_count unchanged.
REQ-021 Redirect asserted together with stall SHALL take the redirect path (stall ignored for that cycle).
REQ-022 Redirect with redirect_target[1:0] != 0 SHALL set fetch_fault and still fetch from the word-aligned target.
REQ-023 A fetch with PC[31:2] >= IMEM_WORDS on an advancing cycle SHALL latch NOP_INSTR with if_id_valid=0, set fetch_fault, not increment fetch_count, and still advance PC by 4.
REQ-024 PC SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 0) without fault from the wrap itself.
REQ-025 fetch_count SHALL wrap modulo 2^32.
REQ-026 fetch_fault SHALL remain set until reset.

Reset
REQ-027 Reset assertion SHALL immediately, without a clock, force PC=RESET_PC, if_id_ir=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_fault=0 and fetch_count=0.
REQ-028 The first fetch after reset release SHALL be from RESET_PC on the first rising edge with reset low.
REQ-029 Reset asserted during a stall or redirect SHALL discard that operation entirely.

Structure
REQ-030 RESET_PC default, NOP_INSTR and the word-size constant 4 SHALL live in the shared pipeline package/header used by all stages.
REQ-031 The IF/ID register SHALL be a separate sub-module named if_id_reg with enable (for stall) and flush (for redirect) inputs; the PC logic stays in if_stage.

Verification
REQ-032 Reset, then 3 cycles with no stall and ir=32'h00222820 -> pc 0,4,8,C; if_id_pc4 4,8,C; fetch_count 3; if_id_valid 1.
REQ-033 Stall high for 2 cycles at pc=8 -> pc stays 8, if_id_* and fetch_count frozen, advance resumes from 8.
REQ-034 Redirect to 32'h40 with stall also high -> next pc=40, if_id_ir=NOP_INSTR, if_id_valid=0; then ir at 40 is latched with if_id_pc4=44.
REQ-035 Redirect to 32'h42 -> pc=40, fetch_fault=1 and stays 1 across later normal cycles.
REQ-036 Redirect to 32'h1FC (word 127) then advance twice -> word 127 latched valid; fetch at 0x200 latches NOP, valid=0, fetch_fault=1, fetch_count not incremented.
REQ-037 Assert reset asynchronously mid-cycle during stall at pc=C -> outputs reach reset values before the next clock edge; fetch restarts at RESET_PC.
